trdb_resync_ctrl: RTL and testbench

TRDB_RESYNC_CTRL -- requirements
Module: trdb_resync_ctrl

---
 rtl/trdb_resync_ctrl.sv | 123 ++++++++++++
 tb/tb_trdb_resync_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/trdb_resync_ctrl.sv
// Trace resynchronisation controller.
// Decides when the trace encoder must emit a sync packet: on trace start,
// periodically when the resync counter reaches its threshold and a qualified
// instruction retires, or forcibly when no qualified instruction shows up
// within TIMEOUT cycles. Every accepted request is followed by a one-cycle
// clear of the resync counter and a short blanking window.
module trdb_resync_ctrl #(
   parameter int TIMEOUT = 16,  // 2..255
   parameter int BLANK   = 2    // 1..7
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       trace_enabled_i,
   input  logic       trace_start_i,
   input  logic       resync_max_i,
   input  logic       qualified_i,
   input  logic       sync_ack_i,
   output logic       sync_req_o,
   output logic [1:0] sync_reason_o,
   output logic       resync_rst_o,
   output logic       busy_o,
   output logic       late_o
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_QUAL = 2'd1,
      REQ       = 2'd2,
      CLEAR     = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      RSN_NONE     = 2'b00,
      RSN_START    = 2'b01,
      RSN_PERIODIC = 2'b10,
      RSN_FORCED   = 2'b11
   } reason_e;

   localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
   localparam logic [2:0] BLANK_LOAD = 3'(BLANK);

   state_e     state_q,  state_d;
   reason_e    reason_q, reason_d;
   logic [7:0] wait_q,   wait_d;
   logic [2:0] blank_q,  blank_d;
   logic       late_q,   late_d;

   // Next-state, counter and reason computation.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d  = state_q;
      reason_d = reason_q;
      wait_d   = wait_q;
      blank_d  = (blank_q != 3'd0) ? blank_q - 3'd1 : 3'd0;
      late_d   = late_q;

      unique case (state_q)
         IDLE: begin
            if (trace_enabled_i && trace_start_i) begin
               state_d  = REQ;
               reason_d = RSN_START;
            end else if (trace_enabled_i && resync_max_i && blank_q == 3'd0) begin
               state_d = WAIT_QUAL;
               wait_d  = 8'd0;
            end
         end
         WAIT_QUAL: begin
            if (!trace_enabled_i) begin
               state_d = IDLE;
            end else if (trace_start_i) begin
               state_d  = REQ;
               reason_d = RSN_START;
            end else if (qualified_i) begin
               state_d  = REQ;
               reason_d = RSN_PERIODIC;
            end else if (wait_q == WAIT_LAST) begin
               state_d  = REQ;
               reason_d = RSN_FORCED;
               late_d   = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         REQ: begin
            // A started request is never withdrawn; only the ack moves on.
            if (sync_ack_i) state_d = CLEAR;
         end
         CLEAR: begin
            state_d = IDLE;
            blank_d = BLANK_LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge, independent of statement order.
      if (!rst_ni) begin
         state_q  <= IDLE;
         reason_q <= RSN_NONE;
         wait_q   <= 8'd0;
         blank_q  <= 3'd0;
         late_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         reason_q <= reason_d;
         wait_q   <= wait_d;
         blank_q  <= blank_d;
         late_q   <= late_d;
      end
   end

   // Outputs are pure decodes of registered state; no input reaches them.
   assign sync_req_o    = (state_q == REQ);
   assign sync_reason_o = (state_q == REQ) ? reason_q : RSN_NONE;
   assign resync_rst_o  = (state_q == CLEAR);
   assign busy_o        = (state_q != IDLE);
   assign late_o        = late_q;

endmodule

// File: tb/tb_trdb_resync_ctrl.sv
// Testbench for trdb_resync_ctrl: directed scenarios followed by random
// traffic, checked every cycle against a timestamp-based reference model
// through an expectation queue consumed by an independent monitor.
module tb_trdb_resync_ctrl;

   localparam int TIMEOUT = 4;
   localparam int BLANK   = 2;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       trace_enabled_i, trace_start_i, resync_max_i, qualified_i, sync_ack_i;
   logic       sync_req_o;
   logic [1:0] sync_reason_o;
   logic       resync_rst_o, busy_o, late_o;

   trdb_resync_ctrl #(.TIMEOUT(TIMEOUT), .BLANK(BLANK)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .trace_enabled_i (trace_enabled_i),
      .trace_start_i   (trace_start_i),
      .resync_max_i    (resync_max_i),
      .qualified_i     (qualified_i),
      .sync_ack_i      (sync_ack_i),
      .sync_req_o      (sync_req_o),
      .sync_reason_o   (sync_reason_o),
      .resync_rst_o    (resync_rst_o),
      .busy_o          (busy_o),
      .late_o          (late_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic       req;
      logic [1:0] reason;
      logic       clr;
      logic       busy;
      logic       late;
   } out_t;

   out_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   checking = 1'b0;

   // Reference model: what the controller is doing, with time kept as
   // absolute cycle numbers instead of counters.
   typedef enum {P_IDLE, P_WAIT, P_REQ, P_CLEAR} phase_e;
   phase_e m_phase;
   int     m_reason;
   bit     m_late;
   int     m_wait_since;   // first cycle spent waiting for a qualified instr
   int     m_blank_until;  // resync_max_i honoured from this cycle on
   int     cyc;

   function automatic out_t model_outputs();
      out_t o;
      o.req    = (m_phase == P_REQ);
      o.reason = (m_phase == P_REQ) ? 2'(m_reason) : 2'b00;
      o.clr    = (m_phase == P_CLEAR);
      o.busy   = (m_phase != P_IDLE);
      o.late   = m_late;
      return o;
   endfunction

   task automatic model_reset();
      m_phase       = P_IDLE;
      m_reason      = 0;
      m_late        = 1'b0;
      m_wait_since  = 0;
      m_blank_until = 0;
   endtask

   task automatic model_step(input bit en, st, rm, q, ack, rstn);
      if (!rstn) begin
         model_reset();
         return;
      end
      case (m_phase)
         P_IDLE:
            if (en && st) begin
               m_phase = P_REQ; m_reason = 1;
            end else if (en && rm && cyc >= m_blank_until) begin
               m_phase = P_WAIT; m_wait_since = cyc + 1;
            end
         P_WAIT:
            if (!en)                                   m_phase = P_IDLE;
            else if (st)                  begin m_phase = P_REQ; m_reason = 1; end
            else if (q)                   begin m_phase = P_REQ; m_reason = 2; end
            else if (cyc - m_wait_since + 1 == TIMEOUT) begin
               m_phase = P_REQ; m_reason = 3; m_late = 1'b1;
            end
         P_REQ:
            if (ack) m_phase = P_CLEAR;
         P_CLEAR: begin
            m_phase       = P_IDLE;
            m_blank_until = cyc + 1 + BLANK;
         end
      endcase
   endtask

   // One clock cycle of stimulus: record the expected outputs for this cycle,
   // apply the inputs, advance the model across the coming edge.
   task automatic drive(input bit en, st, rm, q, ack, rstn);
      exp_q.push_back(model_outputs());
      trace_enabled_i = en;
      trace_start_i   = st;
      resync_max_i    = rm;
      qualified_i     = q;
      sync_ack_i      = ack;
      rst_ni          = rstn;
      model_step(en, st, rm, q, ack, rstn);
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 1);
   endtask

   // Monitor: compares the DUT against the oldest expectation every cycle.
   always @(negedge clk_i) begin
      if (checking) begin
         out_t act, e;
         act = {sync_req_o, sync_reason_o, resync_rst_o, busy_o, late_o};
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL underflow cycle %0d: no expectation queued", cyc);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               n_fail++;
               $display("FAIL outputs cycle %0d: got req=%b rsn=%b clr=%b busy=%b late=%b, want req=%b rsn=%b clr=%b busy=%b late=%b",
                        cyc, act.req, act.reason, act.clr, act.busy, act.late,
                        e.req, e.reason, e.clr, e.busy, e.late);
            end
         end
      end
   end

   initial begin
      trace_enabled_i = 0; trace_start_i = 0; resync_max_i = 0;
      qualified_i = 0; sync_ack_i = 0; rst_ni = 0;
      model_reset();
      cyc = 0;
      @(posedge clk_i);
      #1;
      checking = 1'b1;

      // Reset state.
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1);

      // Start sync: pulse, ack on the third request cycle.
      drive(1, 1, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 1, 1);
      idle_cycles(4);

      // Periodic resync with resync_max/qualified/ack held high: blanking
      // must hold off the next round after each clear.
      for (int i = 0; i < 14; i++) drive(1, 0, 1, 1, 1, 1);
      idle_cycles(3);

      // Forced resync by timeout; late stays set afterwards.
      for (int i = 0; i < 8; i++) drive(1, 0, 1, 0, 0, 1);
      drive(1, 0, 0, 0, 1, 1);
      idle_cycles(4);

      // Abort while waiting for a qualified instruction.
      drive(1, 0, 1, 0, 0, 1);
      drive(0, 0, 1, 1, 0, 1);
      drive(0, 0, 0, 0, 1, 1);
      idle_cycles(2);

      // Collision of start and resync_max in IDLE.
      drive(1, 1, 1, 0, 0, 1);
      drive(1, 0, 1, 0, 0, 1);
      drive(1, 0, 1, 0, 1, 1);
      drive(1, 0, 0, 0, 0, 1);
      idle_cycles(4);

      // Reset in the middle of a request: no clear pulse, late drops.
      drive(1, 1, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 1, 0);
      idle_cycles(3);

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(99) < 90, $urandom_range(99) < 5,
               $urandom_range(99) < 35, $urandom_range(99) < 15,
               $urandom_range(99) < 40, $urandom_range(99) < 99);
      end

      checking = 1'b0;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
